regfile_write_port: RTL
=======================

// Module: regfile_write_port
// PURPOSE
//  Write side of the MIPS register file. It is the counterpart of the bit-sliced 32:1 read muxes.
//  - Accepts write-back requests over a valid/ready handshake.
//  - Decodes the 5-bit destination into a one-hot enable and updates 32 registers. r0 is hardwired to zero.
//  - Runs a sequential clear sweep on request.
//  - Exposes register contents as bit planes, so each read mux takes one 32-bit plane and a 5-bit select.
// PARAMETERS
//  DATA_W   32   register width in bits
//  ADDR_W   5    address width; NREGS = 2**ADDR_W (32)
// PORTS
//  clk        in   1                 single clock; all state updates on its rising edge
//  rst_n      in   1                 synchronous, active-low reset
//  wr_valid   in   1                 write request valid
//  wr_ready   out  1                 port can accept a write this cycle
//  wr_addr    in   ADDR_W            destination register
//  wr_data    in   DATA_W            write-back data
//  clr_req    in   1                 start clear sweep (sampled only in IDLE)
//  busy       out  1                 sweep in progress (state != IDLE)
//  clr_done   out  1                 one-cycle pulse when sweep completes
//  rd_planes  out  DATA_W*NREGS      rd_planes[NREGS*b + r] = bit b of register r
// BEHAVIOUR
//  - Reset: rst_n low at a rising edge clears all registers, state=IDLE and counter=0.
//    Resulting outputs: rd_planes=0, wr_ready=1, busy=0, clr_done=0.
//  - Reset mid-sweep: aborts the sweep immediately; clr_done does not pulse.
//  - Output decode: wr_ready = (state==IDLE); busy = !wr_ready; clr_done = (state==DONE).
//  - Write handshake:
//    - A write is accepted at the rising edge where wr_valid && wr_ready.
//    - reg[wr_addr] <= wr_data on that same edge; the new value is visible on rd_planes in the following cycle.
//    - Latency is 1 cycle. Throughput is 1 write/cycle, back-to-back.
//    - wr_valid while wr_ready=0 is ignored; the source holds the request.
//  - Enable decode: we_onehot = wr_en ? (1 << wr_addr) : 0, with bit 0 forced to 0.
//    A write to r0 is accepted (handshake completes) but r0 stays 0.
//  - FSM:
//    - IDLE --clr_req--> CLEAR, counter <= 1.
//    - CLEAR: on each edge, reg[counter] <= 0 and counter++.
//      At counter==31 the edge clears r31 and moves to DONE; the counter never wraps.
//    - DONE --> IDLE after one cycle.
//    - busy is high for 32 cycles per sweep: 31 CLEAR + 1 DONE.
//  - clr_req in CLEAR or DONE is ignored, not queued.
//  - Simultaneous clr_req and an accepted write in IDLE: the write is performed on that edge, the sweep
//    starts on the same edge, and the written register is zeroed later in the sweep.
//  - rd_planes is driven directly from the registers: no read path logic and no bypass.
// STRUCTURE
//  - Package mips_rf_pkg:
//    - typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t
//    - localparams RF_NREGS=32, RF_ADDR_W=5, RF_ZERO_REG=0
//  - Sub-module dec32: combinational 5-to-32 one-hot decoder with enable, the dual of mux32.
//    It is built as a 2:4 predecode of addr[1:0] and a 3:8 predecode of addr[4:2], ANDed together.
//  - Top level: FSM, 5-bit sweep counter, 32 x DATA_W register array, plane re-packing.
// TESTING
//  1. Reset, then write addr 5 data 32'hDEADBEEF.
//     -> Next cycle reg5=DEADBEEF: rd_planes[32*0+5]=1 and rd_planes[32*4+5]=0. All other regs are 0.
//  2. Write addr 0 data 32'hFFFFFFFF.
//     -> wr_ready=1 and the write is accepted; all 32 bits of r0 in rd_planes remain 0.
//  3. Back-to-back writes addr3=32'h1, addr3=32'h2, addr9=32'h9 on consecutive cycles.
//     -> wr_ready stays 1 and the final state is reg3=2, reg9=9.
//  4. Fill r1..r31 with reg[i]=i, then pulse clr_req. Drive wr_valid=1 throughout.
//     -> busy high for exactly 32 cycles and wr_ready=0 for those 32 cycles; no write lands.
//     -> clr_done is high only in cycle 32; all regs are 0 afterwards.
//  5. Start a sweep as in 4 and assert rst_n=0 at sweep cycle 10.
//     -> Next cycle IDLE, all regs 0, clr_done never pulses, wr_ready=1.
//  6. clr_req together with a write addr7=32'h77 in IDLE.
//     -> reg7 reads 77 for sweep cycles 1..7, then 0; the sweep completes normally.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// ---------------------------------------------------------------------------
// mips_rf_pkg
// Shared types and constants for the MIPS register-file write side.
//   rf_state_t    : sweep FSM states (idle / clearing / one-cycle done)
//   RF_NREGS      : number of architectural registers
//   RF_ADDR_W     : register address width
//   RF_ZERO_REG   : index of the hardwired-zero register
//   rf_mask_zero  : forces the r0 bit of a one-hot enable vector low
// ---------------------------------------------------------------------------
package mips_rf_pkg;

    localparam int RF_NREGS    = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_REG = 0;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_t;

    // r0 must never see an enable, whatever the decoder produced.
    function automatic logic [RF_NREGS-1:0] rf_mask_zero(input logic [RF_NREGS-1:0] onehot);
        logic [RF_NREGS-1:0] masked;
        masked              = onehot;
        masked[RF_ZERO_REG] = 1'b0;
        return masked;
    endfunction

endpackage

// File: rtl/regfile_write_port_dec32.sv
// ---------------------------------------------------------------------------
// dec32
// Combinational 5-to-32 one-hot decoder with enable; the structural dual of
// the 32:1 read mux. Built from a 2:4 predecode of addr[1:0] and a 3:8
// predecode of addr[4:2]; each output is the AND of one line from each.
// Ports:
//   i_en      in   1    decoder enable; all outputs low when 0
//   i_addr    in   5    address to decode
//   o_onehot  out  32   o_onehot[a] = i_en & (i_addr == a)
// ---------------------------------------------------------------------------
module dec32
    import mips_rf_pkg::*;
(
    input  logic                 i_en,
    input  logic [RF_ADDR_W-1:0] i_addr,
    output logic [RF_NREGS-1:0]  o_onehot
);

    logic [3:0] w_pre_lo;
    logic [7:0] w_pre_hi;

    // 2:4 predecode of the low address bits
    always_comb begin
        w_pre_lo                = 4'b0000;
        w_pre_lo[i_addr[1:0]]   = 1'b1;
    end

    // 3:8 predecode of the high address bits, gated by the enable
    always_comb begin
        w_pre_hi                = 8'b0000_0000;
        w_pre_hi[i_addr[4:2]]   = i_en;
    end

    genvar g;
    generate
        for (g = 0; g < RF_NREGS; g++) begin : g_and
            assign o_onehot[g] = w_pre_hi[g / 4] & w_pre_lo[g % 4];
        end
    endgenerate

endmodule

// File: rtl/regfile_write_port.sv
// ---------------------------------------------------------------------------
// regfile_write_port
// Write side of the MIPS register file. Accepts write-back requests over a
// valid/ready handshake, decodes the destination into a one-hot enable,
// keeps r0 at zero, runs a sequential clear sweep on request and exposes
// the register contents as bit planes for the bit-sliced read muxes.
// Ports:
//   clk        in   1               rising-edge clock
//   rst_n      in   1               synchronous active-low reset
//   wr_valid   in   1               write request valid
//   wr_ready   out  1               high while idle; write accepted on valid&&ready
//   wr_addr    in   ADDR_W          destination register
//   wr_data    in   DATA_W          write-back data
//   clr_req    in   1               start clear sweep (only honoured in idle)
//   busy       out  1               sweep in progress
//   clr_done   out  1               one-cycle pulse at sweep end
//   rd_planes  out  DATA_W*NREGS    rd_planes[NREGS*b + r] = bit b of reg r
// ---------------------------------------------------------------------------
module regfile_write_port
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           clr_req,
    output logic                           busy,
    output logic                           clr_done,
    output logic [DATA_W*(2**ADDR_W)-1:0]  rd_planes
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(NREGS - 1);

    rf_state_t             r_state;
    rf_state_t             w_state_nxt;
    logic [ADDR_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]     w_cnt_nxt;
    logic [DATA_W-1:0]     r_regs [NREGS];

    logic                  w_wr_en;
    logic                  w_clr_en;
    logic [NREGS-1:0]      w_wr_raw;
    logic [NREGS-1:0]      w_clr_raw;
    logic [NREGS-1:0]      w_wr_oh;
    logic [NREGS-1:0]      w_clr_oh;

    // Status outputs are pure decodes of the state register.
    assign wr_ready = (r_state == RF_IDLE);
    assign busy     = (r_state != RF_IDLE);
    assign clr_done = (r_state == RF_DONE);

    assign w_wr_en  = wr_valid & wr_ready;
    assign w_clr_en = (r_state == RF_CLEAR);

    dec32 u_wr_dec (
        .i_en     (w_wr_en),
        .i_addr   (wr_addr),
        .o_onehot (w_wr_raw)
    );

    // The sweep counter is decoded with a second copy of the same decoder.
    dec32 u_clr_dec (
        .i_en     (w_clr_en),
        .i_addr   (r_cnt),
        .o_onehot (w_clr_raw)
    );

    assign w_wr_oh  = rf_mask_zero(w_wr_raw);
    assign w_clr_oh = rf_mask_zero(w_clr_raw);

    // State and sweep counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RF_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-counter logic for the clear sweep
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RF_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_cnt_nxt   = CNT_FIRST;
                end else begin
                    w_state_nxt = RF_IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            RF_CLEAR: begin
                // Last register cleared on this edge: stop without wrapping.
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RF_DONE;
                    w_cnt_nxt   = r_cnt;
                end else begin
                    w_state_nxt = RF_CLEAR;
                    w_cnt_nxt   = r_cnt + ADDR_W'(1);
                end
            end
            RF_DONE: begin
                w_state_nxt = RF_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = RF_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Register array: writes only happen in idle and clears only in the
    // sweep, so the two enables never overlap on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_clr_oh[i]) begin
                    r_regs[i] <= '0;
                end else if (w_wr_oh[i]) begin
                    r_regs[i] <= wr_data;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // Plane re-packing: plane b gathers bit b of every register.
    genvar gb, gr;
    generate
        for (gb = 0; gb < DATA_W; gb++) begin : g_plane
            for (gr = 0; gr < NREGS; gr++) begin : g_reg
                assign rd_planes[NREGS*gb + gr] = r_regs[gr][gb];
            end
        end
    endgenerate

endmodule
